calc_ctrl_fsm: RTL and testbench
================================

Name: calc_ctrl_fsm

Overview:
Parametrised next-generation controller for the calculator datapath. It sequences loading of NUM_IN operands into the register file and mode selection. It then runs a start/done handshake with a multi-cycle ALU, supervised by a timeout, and reports done or error. It sits between the board inputs (Go, Next, MS switches) and the register file / ALU.

Parameters:
NUM_IN, 2, number of operands loaded (2..8); IDX_W = max(1, clog2(NUM_IN)) is a localparam
MODE_W, 3, width of mode select
NUM_MODES, 7, valid modes are 1..NUM_MODES; 0 and values above NUM_MODES are invalid
TIMEOUT, 64, maximum cycles from Start to ALU_Done before error (>=2)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  synchronous active-low reset
Go  in  1  level; start a new calculation from IDLE
Next  in  1  advance request; rising-edge detected internally
MS  in  MODE_W  requested mode
ALU_Done  in  1  one-cycle pulse from ALU: result valid
ALU_Err  in  1  qualified by ALU_Done; e.g. divide by zero
WE  out  1  register-file write enable (operand load)
WA  out  IDX_W  register-file write address
Res_WE  out  1  write ALU result into RF[0] (chain feature only)
MS_out  out  MODE_W  mode presented to ALU
Start  out  1  one-cycle ALU start pulse
Done_out  out  1  high while in DONE
Err_out  out  1  high while in ERROR
CS_out  out  4  state code for LEDs

Behaviour:
- Reset: RST_N low at any edge, including mid-EXEC, forces IDLE. idx=0, tmo=0, latched mode=0, all outputs 0, CS_out=0. The Next history register resets to 1, so a Next held high through reset does not generate an edge.
- nxt = Next & ~Next_q. Next_q is registered every cycle. All transitions occur at the same edge where nxt is sampled.
- States and CS_out codes: IDLE=0, LOAD=1, SEL=3, EXEC=4, DONE=11, ERROR=15.
- IDLE: Go=1 -> LOAD with idx=0. Otherwise stay.
- LOAD: WE = nxt (combinational) and WA = idx. On nxt: if idx==NUM_IN-1 -> SEL with idx=0, else idx++. Exactly NUM_IN writes occur; no wrap past NUM_IN-1.
- SEL: on nxt with a valid MS, latch MS into mode -> EXEC. On nxt with an invalid MS, stay in SEL with mode unchanged.
- EXEC: Start=1 in the first EXEC cycle only (registered). MS_out = latched mode throughout EXEC; MS_out=0 in all other states. tmo counts cycles in EXEC.
  - ALU_Done & ~ALU_Err -> DONE.
  - ALU_Done & ALU_Err -> ERROR.
  - tmo reaching TIMEOUT-1 with no ALU_Done -> ERROR.
  - ALU_Done has priority over timeout in the same cycle. Next and Go are ignored in EXEC.
- DONE: Done_out=1. On nxt -> IDLE (see Optional Feature).
- ERROR: Err_out=1. On nxt -> IDLE. Go is ignored.
- ALU_Done outside EXEC is ignored.
- Latency: WE is in the same cycle as the Next rise. Start is 1 cycle after the SEL nxt edge. Done_out is 1 cycle after ALU_Done.
- Outputs other than WE, WA and Res_WE are registered.

Optional Feature:
- Macro CALC_CHAIN_EN.
- Defined: in DONE, an nxt edge with Go=1 asserts Res_WE for that cycle (result written to RF[0]) and moves to SEL, allowing chained operations. An nxt edge with Go=0 -> IDLE.
- Undefined: Res_WE is tied 0 and DONE always returns to IDLE on nxt.

Test Plan:
- NUM_IN=2: reset, Go=1, two Next pulses, MS=1, Next -> WE pulses with WA=0 then 1; Start 1 cycle after the third Next; ALU_Done -> Done_out=1, CS_out=11; Next -> CS_out=0.
- NUM_IN=4 -> exactly 4 WE pulses with WA=0,1,2,3, then CS_out=3; a 5th Next in SEL with MS=0 -> stays in SEL, no WE.
- ALU_Done with ALU_Err=1 -> Err_out=1, CS_out=15; Go=1 ignored; Next -> IDLE.
- TIMEOUT=8, ALU silent -> Err_out asserted 8 cycles after Start; ALU_Done and timeout in the same cycle -> DONE.
- RST_N low for 1 cycle mid-EXEC with Next held high -> all outputs 0, CS_out=0, no spurious advance after reset.
- CALC_CHAIN_EN: in DONE, Go=1 plus Next -> Res_WE one cycle, CS_out=3; a new valid MS and Next -> Start again.

Source files
------------

// File: rtl/calc_ctrl_fsm.sv
// calc_ctrl_fsm
// Sequencer for the calculator datapath: loads NUM_IN operands into the
// register file on Next rising edges and latches a valid mode. It then
// issues a one-cycle Start to the ALU and waits for ALU_Done under a
// TIMEOUT-cycle watchdog. Finally it reports DONE or ERROR until the
// next Next edge.
//
// Build option: define CALC_CHAIN_EN to let DONE write the result back
// into RF[0] (Res_WE) and jump straight to mode select when Go is high.
// Without it, Res_WE is tied low and DONE always returns to IDLE.
//
// state  | code | meaning
// IDLE   |  0   | waiting for Go
// LOAD   |  1   | one operand written per Next edge, WA = idx
// SEL    |  3   | waiting for Next with a valid MS
// EXEC   |  4   | Start issued, waiting for ALU_Done or timeout
// DONE   | 11   | result valid, Done_out high
// ERROR  | 15   | ALU error or timeout, Err_out high

module calc_ctrl_fsm #(
    parameter int NUM_IN    = 2,
    parameter int MODE_W    = 3,
    parameter int NUM_MODES = 7,
    parameter int TIMEOUT   = 64,
    localparam int IDX_W    = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              Go,
    input  logic              Next,
    input  logic [MODE_W-1:0] MS,
    input  logic              ALU_Done,
    input  logic              ALU_Err,
    output logic              WE,
    output logic [IDX_W-1:0]  WA,
    output logic              Res_WE,
    output logic [MODE_W-1:0] MS_out,
    output logic              Start,
    output logic              Done_out,
    output logic              Err_out,
    output logic [3:0]        CS_out
);

    localparam int TMO_W = $clog2(TIMEOUT);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_IN - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_LOAD  = 4'd1,
        S_SEL   = 4'd3,
        S_EXEC  = 4'd4,
        S_DONE  = 4'd11,
        S_ERROR = 4'd15
    } state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [TMO_W-1:0]    tmo_q;
    logic [MODE_W-1:0]   mode_q;
    logic [MODE_W-1:0]   ms_out_q;
    logic                next_q;
    logic                start_q;
    logic                done_q;
    logic                err_q;

    logic                nxt;
    logic                ms_valid;

    // Next history resets high so a Next held through reset is not an edge.
    assign nxt      = Next & ~next_q;
    // Mode 0 and anything above NUM_MODES are rejected in SEL.
    assign ms_valid = (MS != '0) && (32'(MS) <= 32'(NUM_MODES));

    // Sequencer: state, counters and all registered outputs in one place.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            tmo_q    <= '0;
            mode_q   <= '0;
            ms_out_q <= '0;
            next_q   <= 1'b1;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            next_q  <= Next;
            start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (Go) begin
                        state_q <= S_LOAD;
                        idx_q   <= '0;
                    end
                end
                S_LOAD: begin
                    if (nxt) begin
                        if (idx_q == IDX_LAST) begin
                            state_q <= S_SEL;
                            idx_q   <= '0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                S_SEL: begin
                    if (nxt && ms_valid) begin
                        state_q  <= S_EXEC;
                        mode_q   <= MS;
                        ms_out_q <= MS;
                        start_q  <= 1'b1;
                        tmo_q    <= '0;
                    end
                end
                S_EXEC: begin
                    // ALU_Done wins over the timeout in the same cycle.
                    if (ALU_Done) begin
                        ms_out_q <= '0;
                        tmo_q    <= '0;
                        if (ALU_Err) begin
                            state_q <= S_ERROR;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        ms_out_q <= '0;
                        tmo_q    <= '0;
                        state_q  <= S_ERROR;
                        err_q    <= 1'b1;
                    end else begin
                        ms_out_q <= mode_q;
                        tmo_q    <= tmo_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (nxt) begin
                        done_q <= 1'b0;
`ifdef CALC_CHAIN_EN
                        // Chained op: result goes to RF[0], pick next mode.
                        if (Go) begin
                            state_q <= S_SEL;
                        end else begin
                            state_q <= S_IDLE;
                        end
`else
                        state_q <= S_IDLE;
`endif
                    end
                end
                S_ERROR: begin
                    if (nxt) begin
                        err_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    idx_q    <= '0;
                    tmo_q    <= '0;
                    ms_out_q <= '0;
                    done_q   <= 1'b0;
                    err_q    <= 1'b0;
                end
            endcase
        end
    end

    // Register-file strobes follow the Next edge in the same cycle.
    always_comb begin
        WE     = 1'b0;
        WA     = '0;
        Res_WE = 1'b0;
        if (state_q == S_LOAD) begin
            WE = nxt;
            WA = idx_q;
        end
`ifdef CALC_CHAIN_EN
        if (state_q == S_DONE) begin
            Res_WE = nxt & Go;
        end
`endif
    end

    assign MS_out   = ms_out_q;
    assign Start    = start_q;
    assign Done_out = done_q;
    assign Err_out  = err_q;
    assign CS_out   = state_q;

endmodule

// File: tb/tb_calc_ctrl_fsm.sv
// Bench for calc_ctrl_fsm with NUM_IN=4, NUM_MODES=5, TIMEOUT=8.
// Expected WA values, Start modes and Res_WE strobes are queued when
// stimulus is driven. A negedge monitor pops and compares them when
// the DUT strobes.

module tb_calc_ctrl_fsm;

    localparam int NUM_IN    = 4;
    localparam int MODE_W    = 3;
    localparam int NUM_MODES = 5;
    localparam int TIMEOUT   = 8;
    localparam int IDX_W     = 2;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              Go;
    logic              Next;
    logic [MODE_W-1:0] MS;
    logic              ALU_Done;
    logic              ALU_Err;
    logic              WE;
    logic [IDX_W-1:0]  WA;
    logic              Res_WE;
    logic [MODE_W-1:0] MS_out;
    logic              Start;
    logic              Done_out;
    logic              Err_out;
    logic [3:0]        CS_out;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    int q_wa[$];
    int q_start[$];
    int q_res[$];

    calc_ctrl_fsm #(
        .NUM_IN(NUM_IN),
        .MODE_W(MODE_W),
        .NUM_MODES(NUM_MODES),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .Go(Go),
        .Next(Next),
        .MS(MS),
        .ALU_Done(ALU_Done),
        .ALU_Err(ALU_Err),
        .WE(WE),
        .WA(WA),
        .Res_WE(Res_WE),
        .MS_out(MS_out),
        .Start(Start),
        .Done_out(Done_out),
        .Err_out(Err_out),
        .CS_out(CS_out)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_next();
        Next = 1'b1;
        tick();
        Next = 1'b0;
        tick();
    endtask

    // From IDLE: load all operands, then select mode m; returns in first EXEC cycle.
    task automatic run_to_exec(input int m);
        Go = 1'b1;
        tick();
        Go = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            q_wa.push_back(i);
            pulse_next();
        end
        MS = MS_W(m);
        q_start.push_back(m);
        Next = 1'b1;
        tick();
        Next = 1'b0;
    endtask

    function automatic logic [MODE_W-1:0] MS_W(input int m);
        return MODE_W'(m);
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_cs"}, 32'(CS_out), 32'd0);
        chk({tag, "_done"}, 32'(Done_out), 32'd0);
        chk({tag, "_err"}, 32'(Err_out), 32'd0);
        chk({tag, "_start"}, 32'(Start), 32'd0);
        chk({tag, "_msout"}, 32'(MS_out), 32'd0);
        chk({tag, "_we"}, 32'(WE), 32'd0);
        chk({tag, "_reswe"}, 32'(Res_WE), 32'd0);
    endtask

    // Strobe monitor: every WE/Start/Res_WE must match a queued expectation.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (WE) begin
                if (q_wa.size() == 0) chk("we_unexpected", 32'(WE), 32'd0);
                else chk("we_wa", 32'(WA), 32'(q_wa.pop_front()));
            end
            if (Start) begin
                if (q_start.size() == 0) chk("start_unexpected", 32'(Start), 32'd0);
                else chk("start_msout", 32'(MS_out), 32'(q_start.pop_front()));
            end
            if (Res_WE) begin
                if (q_res.size() == 0) chk("reswe_unexpected", 32'(Res_WE), 32'd0);
                else chk("reswe", 32'(Res_WE), 32'(q_res.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST_N = 1'b0; Go = 1'b0; Next = 1'b0; MS = '0;
        ALU_Done = 1'b0; ALU_Err = 1'b0;
        repeat (3) tick();
        check_idle_outputs("reset");
        chk("reset_wa", 32'(WA), 32'd0);
        RST_N = 1'b1;
        mon_en = 1'b1;
        tick();

        // Next in IDLE does nothing
        pulse_next();
        chk("idle_next_cs", 32'(CS_out), 32'd0);

        // Load four operands, then reject invalid modes
        Go = 1'b1;
        tick();
        Go = 1'b0;
        chk("load_cs", 32'(CS_out), 32'd1);
        for (int i = 0; i < NUM_IN; i++) begin
            q_wa.push_back(i);
            pulse_next();
        end
        chk("sel_cs", 32'(CS_out), 32'd3);
        MS = 3'd0;
        pulse_next();
        chk("sel_ms0_cs", 32'(CS_out), 32'd3);
        MS = 3'd6;
        pulse_next();
        chk("sel_ms6_cs", 32'(CS_out), 32'd3);
        chk("sel_ms6_start", 32'(Start), 32'd0);

        // Valid mode -> EXEC with one Start, then normal completion
        MS = 3'd2;
        q_start.push_back(2);
        Next = 1'b1;
        tick();
        Next = 1'b0;
        chk("exec_cs", 32'(CS_out), 32'd4);
        chk("exec_start0", 32'(Start), 32'd1);
        chk("exec_msout0", 32'(MS_out), 32'd2);
        tick();
        chk("exec_start1", 32'(Start), 32'd0);
        chk("exec_msout1", 32'(MS_out), 32'd2);
        ALU_Done = 1'b1;
        tick();
        ALU_Done = 1'b0;
        chk("done_cs", 32'(CS_out), 32'd11);
        chk("done_out", 32'(Done_out), 32'd1);
        chk("done_msout", 32'(MS_out), 32'd0);
        ALU_Done = 1'b1;
        tick();
        ALU_Done = 1'b0;
        chk("done_ignore_alu", 32'(CS_out), 32'd11);
        pulse_next();
        check_idle_outputs("done_exit");

        // ALU error path; Go ignored in ERROR
        run_to_exec(4);
        ALU_Done = 1'b1; ALU_Err = 1'b1;
        tick();
        ALU_Done = 1'b0; ALU_Err = 1'b0;
        chk("err_cs", 32'(CS_out), 32'd15);
        chk("err_out", 32'(Err_out), 32'd1);
        chk("err_done", 32'(Done_out), 32'd0);
        Go = 1'b1;
        tick();
        Go = 1'b0;
        chk("err_go_ignored", 32'(CS_out), 32'd15);
        pulse_next();
        check_idle_outputs("err_exit");

        // Silent ALU: error exactly TIMEOUT cycles after Start
        run_to_exec(5);
        repeat (TIMEOUT - 1) tick();
        chk("tmo_before_cs", 32'(CS_out), 32'd4);
        chk("tmo_before_err", 32'(Err_out), 32'd0);
        tick();
        chk("tmo_cs", 32'(CS_out), 32'd15);
        chk("tmo_err", 32'(Err_out), 32'd1);
        pulse_next();
        chk("tmo_exit_cs", 32'(CS_out), 32'd0);

        // ALU_Done in the same cycle as the timeout -> DONE
        run_to_exec(1);
        repeat (TIMEOUT - 1) tick();
        ALU_Done = 1'b1;
        tick();
        ALU_Done = 1'b0;
        chk("race_cs", 32'(CS_out), 32'd11);
        chk("race_done", 32'(Done_out), 32'd1);
        chk("race_err", 32'(Err_out), 32'd0);
        pulse_next();

        // Reset mid-EXEC with Next held high; no edge afterwards
        run_to_exec(3);
        tick();
        tick();
        Next = 1'b1;
        RST_N = 1'b0;
        tick();
        check_idle_outputs("midrst");
        RST_N = 1'b1;
        tick();
        tick();
        chk("postrst_cs", 32'(CS_out), 32'd0);
        Go = 1'b1;
        tick();
        Go = 1'b0;
        chk("postrst_load", 32'(CS_out), 32'd1);
        tick();
        chk("postrst_we", 32'(WE), 32'd0);
        Next = 1'b0;
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        tick();

        // DONE with Go and Next: chain or plain return
        run_to_exec(4);
        ALU_Done = 1'b1;
        tick();
        ALU_Done = 1'b0;
        chk("chain_pre_cs", 32'(CS_out), 32'd11);
`ifdef CALC_CHAIN_EN
        q_res.push_back(1);
`endif
        Go = 1'b1;
        Next = 1'b1;
        tick();
        Go = 1'b0;
        Next = 1'b0;
`ifdef CALC_CHAIN_EN
        chk("chain_sel_cs", 32'(CS_out), 32'd3);
        tick();
        MS = 3'd2;
        q_start.push_back(2);
        Next = 1'b1;
        tick();
        Next = 1'b0;
        chk("chain_exec_cs", 32'(CS_out), 32'd4);
        chk("chain_start", 32'(Start), 32'd1);
        chk("chain_msout", 32'(MS_out), 32'd2);
        ALU_Done = 1'b1;
        tick();
        ALU_Done = 1'b0;
        chk("chain_done_cs", 32'(CS_out), 32'd11);
        pulse_next();
        chk("chain_idle_cs", 32'(CS_out), 32'd0);
`else
        chk("nochain_cs", 32'(CS_out), 32'd0);
        chk("nochain_done", 32'(Done_out), 32'd0);
        tick();
`endif
        tick();

        chk("q_wa_left", 32'(q_wa.size()), 32'd0);
        chk("q_start_left", 32'(q_start.size()), 32'd0);
        chk("q_res_left", 32'(q_res.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
